matrix_result_formatter: RTL and testbench

Converts a stream of signed 32-bit matrix result elements into ASCII decimal text for the UART transmit path. Elements are separated by a space, and each row ends with CR LF. It sits between the calculator core's result stream and the UART transmitter, which is driven through a valid/ready byte handshake (`tx_ready` = not busy). It is the transmit-side counterpart of the ASCII matrix input parsing on the receive path.

---
 rtl/matrix_result_formatter.sv | 190 +++++++++++++++++++
 tb/tb_matrix_result_formatter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_formatter.sv
// matrix_result_formatter: signed 32-bit element stream to ASCII decimal bytes for the UART transmitter
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_data, in_eol, in_last         element value, end of row, end of matrix
//   in_valid / in_ready              element handshake
//   tx_data, tx_valid / tx_ready     ASCII byte handshake toward the transmitter
//   busy                             element being formatted
//   done                             one-cycle pulse after the final LF of the matrix
module matrix_result_formatter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eol,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, SIGN, CALC, EMIT, SEP, CR, LF, FIN} state_t;
  state_t state_q, state_d;
  logic [31:0] mag_q, mag_d, pow_k;
  logic [3:0] k_q, k_d, digit_q, digit_d;
  logic [1:0] guard_q, guard_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic eol_q, eol_d, last_q, last_d, started_q, started_d;
  logic tx_valid_q, tx_valid_d, in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
  logic fin;
  function automatic logic [31:0] pow10(input logic [3:0] k);
    case (k)
      4'd9: pow10 = 32'd1000000000;
      4'd8: pow10 = 32'd100000000;
      4'd7: pow10 = 32'd10000000;
      4'd6: pow10 = 32'd1000000;
      4'd5: pow10 = 32'd100000;
      4'd4: pow10 = 32'd10000;
      4'd3: pow10 = 32'd1000;
      4'd2: pow10 = 32'd100;
      4'd1: pow10 = 32'd10;
      default: pow10 = 32'd1;
    endcase
  endfunction
  assign pow_k = pow10(k_q);
  // an emitting state may advance once its byte (if any) is gone and the guard is on its last cycle
  assign fin = !tx_valid_q && guard_q <= 2'd1;
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    k_d = k_q;
    digit_d = digit_q;
    eol_d = eol_q;
    last_d = last_q;
    started_d = started_q;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    guard_d = (guard_q == 2'd0) ? 2'd0 : guard_q - 2'd1;
    in_ready_d = in_ready_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
      guard_d = 2'd2;
    end
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          busy_d = 1'b1;
          mag_d = in_data[DATA_WIDTH-1] ? -in_data : in_data;
          eol_d = in_eol | in_last;
          last_d = in_last;
          k_d = 4'd9;
          digit_d = 4'd0;
          started_d = 1'b0;
          state_d = in_data[DATA_WIDTH-1] ? SIGN : CALC;
          // the sign byte is offered straight from the accept edge
          if (in_data[DATA_WIDTH-1]) begin
            tx_valid_d = 1'b1;
            tx_data_d = 8'h2D;
          end
        end
      end
      SIGN: if (fin) state_d = CALC;
      CALC: begin
        if (mag_q >= pow_k) begin
          mag_d = mag_q - pow_k;
          digit_d = digit_q + 4'd1;
        end else begin
          state_d = EMIT;
          // leading zeros are suppressed, but the units digit always prints
          if (digit_q != 4'd0 || started_q || k_q == 4'd0) begin
            tx_valid_d = 1'b1;
            tx_data_d = {4'h3, digit_q};
            started_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (fin) begin
          if (k_q != 4'd0) begin
            k_d = k_q - 4'd1;
            digit_d = 4'd0;
            state_d = CALC;
          end else begin
            state_d = SEP;
            if (!eol_q) begin
              tx_valid_d = 1'b1;
              tx_data_d = 8'h20;
            end
          end
        end
      end
      SEP: begin
        if (fin) begin
          if (eol_q) begin
            state_d = CR;
            tx_valid_d = 1'b1;
            tx_data_d = 8'h0D;
          end else begin
            state_d = IDLE;
            in_ready_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      CR: begin
        if (fin) begin
          state_d = LF;
          tx_valid_d = 1'b1;
          tx_data_d = 8'h0A;
        end
      end
      LF: begin
        if (fin) begin
          state_d = last_q ? FIN : IDLE;
          done_d = last_q;
          in_ready_d = !last_q;
          busy_d = last_q;
        end
      end
      default: begin
        state_d = IDLE;
        in_ready_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q <= '0;
      k_q <= '0;
      digit_q <= '0;
      guard_q <= '0;
      eol_q <= 1'b0;
      last_q <= 1'b0;
      started_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      k_q <= k_d;
      digit_q <= digit_d;
      guard_q <= guard_d;
      eol_q <= eol_d;
      last_q <= last_d;
      started_q <= started_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign in_ready = in_ready_q;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_matrix_result_formatter.sv
// tb_matrix_result_formatter: scoreboard bench for the ASCII result formatter
module tb_matrix_result_formatter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic in_eol = 1'b0, in_last = 1'b0, in_valid = 1'b0, tx_ready = 1'b1;
  logic in_ready, tx_valid, busy, done;
  logic [7:0] tx_data;
  int tests = 0, fails = 0, done_cnt = 0, accepts = 0, cyc = 0, last_xfer = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hold_data = '0;
  logic prev_hold = 1'b0, prev_valid = 1'b0, have_xfer = 1'b0;

  matrix_result_formatter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_eol(in_eol), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void push_elem(input logic [31:0] d, input logic eol, input logic last);
    string s = $sformatf("%0d", $signed(d));
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (eol || last) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else exp_q.push_back(8'h20);
  endfunction

  // scoreboard and protocol monitor, sampled half a cycle away from the active edge
  always @(negedge clk) begin
    logic [7:0] e;
    int gap;
    cyc++;
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_valid = 1'b0;
      have_xfer = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        accepts++;
        push_elem(in_data, in_eol, in_last);
      end
      if (prev_hold) begin
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
          fails++;
          $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, hold_data);
        end
      end
      if (tx_valid && !prev_valid && have_xfer) begin
        tests++;
        gap = cyc - last_xfer;
        if (tx_data == 8'h0A ? gap != 3 : gap < 3) begin
          fails++;
          $display("FAIL tx_guard: byte %h rose %0d cycles after transfer, required %s3", tx_data, gap, tx_data == 8'h0A ? "" : ">=");
        end
      end
      if (tx_valid && tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_byte: got %h, required no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            fails++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, e);
          end
        end
        last_xfer = cyc;
        have_xfer = 1'b1;
      end
      if (done) done_cnt++;
      prev_hold = tx_valid && !tx_ready;
      hold_data = tx_data;
      prev_valid = tx_valid;
    end
  end

  task automatic send(input logic [31:0] d, input logic eol, input logic last);
    int n = 0;
    in_data = d;
    in_eol = eol;
    in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!(in_ready && !busy)) begin
      fails++;
      $display("FAIL %s_idle: in_ready=%b busy=%b, required 1 0", name, in_ready, busy);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({tx_valid, tx_data, in_ready, busy, done} !== 12'h0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b data=%h in_ready=%b busy=%b done=%b, required all 0", tx_valid, tx_data, in_ready, busy, done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_early: in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_rise: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero;
    int d0 = done_cnt, n = 0;
    tx_ready = 1'b1;
    send(32'd0, 1'b0, 1'b1);
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL zero_done: done=%b, required 1", done);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL zero_after_done: in_ready=%b done=%b, required 1 0", in_ready, done);
    end
    wait_idle("zero");
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL zero_done_count: %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_extremes;
    int d0 = done_cnt;
    tx_ready = 1'b1;
    send(32'h80000000, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h2D) begin
      fails++;
      $display("FAIL extreme_first_cycle: busy=%b in_ready=%b valid=%b data=%h, required 1 0 1 2d", busy, in_ready, tx_valid, tx_data);
    end
    wait_idle("extreme_min");
    send(32'h7FFFFFFF, 1'b0, 1'b1);
    wait_idle("extreme_max");
    send(32'hFFFFFFFF, 1'b0, 1'b1);
    wait_idle("extreme_m1");
    tests++;
    if (done_cnt - d0 != 2) begin
      fails++;
      $display("FAIL extreme_done_count: %0d, required 2", done_cnt - d0);
    end
  endtask

  task automatic test_matrix;
    int d0 = done_cnt;
    tx_ready = 1'b1;
    send(32'd1, 1'b0, 1'b0);
    send(-32'sd2, 1'b1, 1'b0);
    send(32'd30, 1'b0, 1'b0);
    send(32'd400, 1'b1, 1'b1);
    wait_idle("matrix");
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL matrix_done_count: %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_backpressure;
    tx_ready = 1'b0;
    send(32'd105, 1'b1, 1'b1);
    for (int b = 0; b < 5; b++) begin
      int n = 0;
      @(negedge clk);
      while (!tx_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (!tx_valid) begin
        fails++;
        $display("FAIL bp_wait: byte %0d valid=%b, required 1", b, tx_valid);
      end
      if (b == 1) begin
        for (int j = 0; j < 20; j++) begin
          tests++;
          if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin
            fails++;
            $display("FAIL bp_hold: cycle %0d valid=%b data=%h, required 1 30", j, tx_valid, tx_data);
          end
          @(negedge clk);
        end
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle("bp");
  endtask

  task automatic test_reset_mid;
    int d0;
    tx_ready = 1'b1;
    send(32'd123456, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_reset: valid=%b busy=%b in_ready=%b, required 0 0 0", tx_valid, busy, in_ready);
    end
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    send(32'd7, 1'b0, 1'b1);
    wait_idle("rmid");
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL rmid_done_count: %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_holdoff;
    int a0 = accepts;
    tx_ready = 1'b1;
    in_last = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 32'(i * 7919 - 1000);
      in_eol = i[2];
      @(negedge clk);
      tests++;
      if (in_ready && busy) begin
        fails++;
        $display("FAIL holdoff_ready_busy: in_ready=%b busy=%b, required not both 1", in_ready, busy);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle("holdoff");
    tests++;
    if (accepts - a0 < 2) begin
      fails++;
      $display("FAIL holdoff_accepts: %0d, required >=2", accepts - a0);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_extremes();
    test_matrix();
    test_backpressure();
    test_reset_mid();
    test_holdoff();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
